// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RSP_I,
    RSP_D
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared port.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int word_width = WORD_WIDTH
) ();

  logic                  if_req;
  logic [word_width-1:0] if_addr;
  logic                  if_ready;
  logic [word_width-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [word_width-1:0] d_addr;
  logic [word_width-1:0] d_wdata;
  logic                  d_ready;
  logic [word_width-1:0] d_rdata;

  logic                  mem_we;
  logic [word_width-1:0] mem_addr;
  logic [word_width-1:0] mem_wdata;
  logic [word_width-1:0] mem_rdata;

  logic                  stall_if;
  logic                  stall_mem;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_ready, if_rdata,
    output d_ready, d_rdata,
    output mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_ready, if_rdata,
    input  d_ready, d_rdata,
    input  mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants taken while fetch is waiting.
module starve_counter #(
  parameter int limit = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int CW = $clog2(limit + 1);
  localparam logic [CW-1:0] LIM = CW'(limit);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && r_cnt != LIM) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one synchronous-read memory port.
// Data has priority; fetch is promoted after a run of data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int word_width   = WORD_WIDTH,
  parameter int starve_limit = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e            r_state;
  logic                  r_mem_we;
  logic [word_width-1:0] r_mem_addr;
  logic [word_width-1:0] r_mem_wdata;
  logic                  r_if_ready;
  logic                  r_d_ready;

  logic w_arb;
  logic w_pick_i;
  logic w_pick_d;
  logic w_inc;
  logic w_at_limit;

  always_comb begin
    w_arb    = r_state inside {IDLE, RSP_I, RSP_D};
    w_pick_i = w_arb & bus.if_req
             & (~bus.d_req | w_at_limit);
    w_pick_d = w_arb & bus.d_req & ~w_pick_i;
    w_inc    = w_pick_d & bus.if_req;
  end

  starve_counter #(
    .limit(starve_limit)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_inc),
    .i_clr     (w_pick_i),
    .o_at_limit(w_at_limit)
  );

  // Grant-cycle bus values are captured at the arbitration edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
    end else begin
      r_if_ready  <= (r_state == GNT_I);
      r_d_ready   <= (r_state == GNT_D);
      r_mem_we    <= w_pick_d & bus.d_we;
      r_mem_addr  <= w_pick_i ? bus.if_addr
                   : w_pick_d ? bus.d_addr
                   : '0;
      r_mem_wdata <= w_pick_d ? bus.d_wdata : '0;
      unique case (1'b1)
        w_pick_i:           r_state <= GNT_I;
        w_pick_d:           r_state <= GNT_D;
        (r_state == GNT_I): r_state <= RSP_I;
        (r_state == GNT_D): r_state <= RSP_D;
        default:            r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.d_ready   = r_d_ready;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_ready;
  assign bus.stall_mem = bus.d_req & ~r_d_ready;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter word_width, default 32, the data/address width.
REQ-002 The block SHALL have parameter starve_limit, default 4, the maximum consecutive data grants while fetch waits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port if_req, input, 1, fetch read request, held until if_ready.
REQ-006 The block SHALL have port if_addr, input, word_width, fetch address, stable while if_req.
REQ-007 The block SHALL have port if_ready, output, 1, one-cycle pulse: fetch access complete, if_rdata valid.
REQ-008 The block SHALL have port if_rdata, output, word_width, fetch read data.
REQ-009 The block SHALL have port d_req, input, 1, data-side request, held until d_ready.
REQ-010 The block SHALL have port d_we, input, 1, data-side write (1) or read (0).
REQ-011 The block SHALL have port d_addr, input, word_width, data address.
REQ-012 The block SHALL have port d_wdata, input, word_width, store data.
REQ-013 The block SHALL have port d_ready, output, 1, one-cycle pulse: data access complete.
REQ-014 The block SHALL have port d_rdata, output, word_width, load data.
REQ-015 The block SHALL have ports mem_we (output, 1), mem_addr (output, word_width), mem_wdata (output, word_width), which drive the shared single-port memory.
REQ-016 The block SHALL have port mem_rdata, input, word_width, synchronous-read memory data, valid one cycle after mem_addr.
REQ-017 The block SHALL have ports stall_if and stall_mem, output, 1 each, which are stall requests to the hazard unit.

Function
REQ-018 FSM states SHALL be IDLE, GNT_I, GNT_D, RSP_I, RSP_D.
REQ-019 Arbitration SHALL happen in IDLE, RSP_I and RSP_D: d_req wins unless if_req=1 and starve_cnt==starve_limit, in which case fetch wins; with neither request, next state is IDLE.
REQ-020 GNT_x SHALL last exactly one cycle: mem_addr = granted address; mem_we = d_we in GNT_D only, else 0; mem_wdata = d_wdata.
REQ-021 RSP_x SHALL follow GNT_x: x_ready=1 for that cycle; x_rdata = mem_rdata; the next grant may be issued in the same cycle (2 cycles per access, back-to-back).
REQ-022 if_rdata and d_rdata SHALL pass mem_rdata combinationally; they are meaningful only while the matching ready is high.
REQ-023 stall_if SHALL equal if_req & ~if_ready; stall_mem SHALL equal d_req & ~d_ready.
REQ-024 starve_cnt SHALL increment on each data grant while if_req=1, saturate at starve_limit, clear on each fetch grant, and hold otherwise; width is clog2(starve_limit+1).
REQ-025 A request deasserted after its grant SHALL still complete: the RSP cycle and ready pulse occur regardless.
REQ-026 A simultaneous request at reset release SHALL be arbitrated on the first clock edge with reset high (data wins, count 0).
REQ-027 Write grants SHALL still produce d_ready in RSP_D; d_rdata is don't-care for writes.
REQ-028 With idle outputs, mem_addr SHALL be 0 and mem_we 0.

Reset
REQ-029 While reset=0, the state SHALL be IDLE, starve_cnt=0, and mem_we, if_ready, d_ready all 0, immediately and asynchronously.
REQ-030 Reset asserted during GNT_D with d_we=1 SHALL drop mem_we at once; no ready pulse is issued for the aborted access.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum type and the default word_width constant.
REQ-032 The saturating starvation counter SHALL be one sub-module, starve_counter, parameterised by limit.

Verification
REQ-033 Fetch only, if_addr=0x10, mem_rdata=0x00500093 -> GNT_I then RSP_I; if_ready pulses in cycle 2 with if_rdata=0x00500093.
REQ-034 Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle with those values; d_ready pulses in the following cycle.
REQ-035 if_req and d_req both held for 12 cycles with starve_limit=4 -> grant order D,D,D,D,I,D; stall_if stays 1 until the fetch RSP.
REQ-036 d_req dropped the cycle after GNT_D -> d_ready still pulses once; FSM returns to IDLE.
REQ-037 reset pulled low mid-GNT_D write -> mem_we=0 within the same cycle, no d_ready, state IDLE, counter 0 after release.
REQ-038 Back-to-back loads 0x100/0x104 -> d_ready in cycles 2 and 4; mem_addr=0x104 in cycle 3.
